bytes_emitter: RTL

- Serializer for the byte-stream side of the parsing layer: parsers consume bytes, this block produces them.
- Accepts whole tokens (1..MAX_LEN bytes, packed in parallel) on a valid/ready port.
- Emits the tokens one byte per cycle on a registered valid/ready byte stream, marking frame ends.
- Sits in front of any byte-consuming stage, e.g. a loopback to the character/bytes parsers or a UART transmit path.

---
 rtl/bytes_emitter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/bytes_emitter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// bytes_emitter
//
// Serializer that takes whole tokens (1..MAX_LEN bytes packed in parallel) on
// a valid/ready port and emits them one byte per cycle on a registered
// valid/ready byte stream. The last byte of a token that carried tok_last is
// flagged with out_last. A new token can be accepted in the same cycle as the
// final byte handshake of the current one, so back-to-back tokens stream
// without bubbles.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   tok_valid/ready - token handshake (tok_ready is combinational)
//   tok_data        - token bytes, byte i at [8i+7:8i], byte 0 sent first
//   tok_len         - number of valid bytes, 0..MAX_LEN legal range
//   tok_last        - token closes a frame
//   out_valid/ready - byte stream handshake (out_valid registered)
//   out_byte        - emitted byte
//   out_last        - final byte of a frame-ending token
//   busy            - a token is being emitted
//   err_len         - one-cycle pulse when an over-long token was dropped
//   bytes_sent      - wrapping count of output handshakes
// ---------------------------------------------------------------------------
module bytes_emitter #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tok_valid,
    output logic                   tok_ready,
    input  logic [8*MAX_LEN-1:0]   tok_data,
    input  logic [LEN_W-1:0]       tok_len,
    input  logic                   tok_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_byte,
    output logic                   out_last,
    output logic                   busy,
    output logic                   err_len,
    output logic [CNT_W-1:0]       bytes_sent
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]             state_q,      state_d;
    logic                   init_q,       init_d;
    logic [8*MAX_LEN-1:0]   tok_buf_q,    tok_buf_d;
    logic [LEN_W-1:0]       idx_q,        idx_d;
    logic [LEN_W-1:0]       len_q,        len_d;
    logic                   last_q,       last_d;
    logic                   out_valid_q,  out_valid_d;
    logic [7:0]             out_byte_q,   out_byte_d;
    logic                   out_last_q,   out_last_d;
    logic                   err_len_q,    err_len_d;
    logic [CNT_W-1:0]       bytes_sent_q, bytes_sent_d;

    logic out_hs;
    logic final_byte;
    logic tok_hs;
    logic len_ok;
    logic len_bad;
    logic load;

    // Handshake and length qualifiers. init_q keeps tok_ready low while reset
    // is asserted and until the first edge after it is released.
    always_comb begin
        out_hs     = out_valid_q && out_ready;
        final_byte = (state_q == ST_EMIT) && (idx_q == (len_q - LEN_W'(1)));
        tok_ready  = init_q && ((state_q == ST_IDLE) || (final_byte && out_ready));
        tok_hs     = tok_valid && tok_ready;
        len_ok     = (tok_len != '0) && (tok_len <= LEN_W'(MAX_LEN));
        len_bad    = (tok_len > LEN_W'(MAX_LEN));
    end

    // Next-state logic. A token is loaded either from IDLE or on the final
    // byte handshake in EMIT; zero-length tokens are silently consumed and
    // over-long ones raise err_len for one cycle.
    always_comb begin
        state_d   = state_q;
        init_d    = 1'b1;
        tok_buf_d = tok_buf_q;
        idx_d     = idx_q;
        len_d     = len_q;
        last_d    = last_q;
        err_len_d = 1'b0;
        load      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tok_hs) begin
                    if (len_ok) begin
                        load = 1'b1;
                    end else if (len_bad) begin
                        err_len_d = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (out_hs) begin
                    if (!final_byte) begin
                        idx_d = idx_q + LEN_W'(1);
                    end else if (tok_hs && len_ok) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        if (tok_hs && len_bad) begin
                            err_len_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            state_d   = ST_EMIT;
            tok_buf_d = tok_data;
            len_d     = tok_len;
            last_d    = tok_last;
            idx_d     = '0;
        end
    end

    // Output registers are computed from the next state so the byte for the
    // new index is already presented in the cycle following a handshake.
    always_comb begin
        out_valid_d = (state_d == ST_EMIT);
        out_byte_d  = 8'h00;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (out_valid_d && (idx_d == LEN_W'(i))) begin
                out_byte_d = tok_buf_d[8*i +: 8];
            end
        end
        out_last_d   = out_valid_d && last_d && (idx_d == (len_d - LEN_W'(1)));
        bytes_sent_d = bytes_sent_q + CNT_W'(out_hs);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            init_q       <= 1'b0;
            tok_buf_q    <= '0;
            idx_q        <= '0;
            len_q        <= '0;
            last_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_byte_q   <= 8'h00;
            out_last_q   <= 1'b0;
            err_len_q    <= 1'b0;
            bytes_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            init_q       <= init_d;
            tok_buf_q    <= tok_buf_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            last_q       <= last_d;
            out_valid_q  <= out_valid_d;
            out_byte_q   <= out_byte_d;
            out_last_q   <= out_last_d;
            err_len_q    <= err_len_d;
            bytes_sent_q <= bytes_sent_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_byte   = out_byte_q;
    assign out_last   = out_last_q;
    assign busy       = (state_q == ST_EMIT);
    assign err_len    = err_len_q;
    assign bytes_sent = bytes_sent_q;

endmodule
